// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, FSM state constants and the FIFO entry type for the
// register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int XLEN      = 32;

    localparam logic [0:0] ARB_PRIO  = 1'b0;
    localparam logic [0:0] ARB_FORCE = 1'b1;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    // One-hot register mask; x0 never marks a bit.
    function automatic logic [31:0] rd_onehot(input logic [RF_ADDR_W-1:0] rd);
        logic [31:0] m;
        m = '0;
        if (rd != '0) m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Synchronous FIFO of {rd,data} for the secondary writer. Exposes
// full/empty/count plus a per-slot rd/valid view for the hazard scoreboard.
module regfile_wb_arbiter_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  wb_entry_t                  push_entry,
    output wb_entry_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [CW-1:0]              count,
    output logic [DEPTH-1:0]           slot_valid,
    output logic [DEPTH*RF_ADDR_W-1:0] slot_rd,
    output logic [AW-1:0]              head_idx
);

    wb_entry_t        mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_n;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head     = mem[rd_ptr];
    assign head_idx = rd_ptr;

    // Slot occupancy: push and pop never target the same slot when both fire.
    always_comb begin
        valid_n = valid;
        if (do_pop)  valid_n[rd_ptr] = 1'b0;
        if (do_push) valid_n[wr_ptr] = 1'b1;
    end

    // Per-slot rd view for the scoreboard.
    always_comb begin
        slot_rd = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_rd[i*RF_ADDR_W +: RF_ADDR_W] = mem[i].rd;
        end
    end

    assign slot_valid = valid;

    // Entry storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    // Pointers, count and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            valid  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt   <= cnt + CW'(do_push) - CW'(do_pop);
            valid <= valid_n;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, the
// secondary writer is queued, and a starvation counter forces one secondary
// write by stalling the pipeline for a single cycle.
// Optional feature: define WB_ARB_SCOREBOARD_EN to add the pending_mask output.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_wb_en,
    input  logic [RF_ADDR_W-1:0] pipe_wb_rd,
    input  logic [XLEN-1:0]      pipe_wb_data,
    output logic                 pipe_stall,
    input  logic                 sec_valid,
    input  logic [RF_ADDR_W-1:0] sec_rd,
    input  logic [XLEN-1:0]      sec_data,
    output logic                 sec_ready,
`ifdef WB_ARB_SCOREBOARD_EN
    output logic [31:0]          pending_mask,
`endif
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_wa,
    output logic [XLEN-1:0]      rf_wd
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

    logic [0:0]           state;
    logic [0:0]           state_n;
    logic [CNT_W-1:0]     starve_cnt;
    logic [CNT_W-1:0]     starve_cnt_n;

    logic                 p_wr;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    wb_entry_t            fifo_head;
    wb_entry_t            push_entry;
    logic [DEPTH-1:0]     slot_valid;
    logic [DEPTH*RF_ADDR_W-1:0] slot_rd;
    logic [AW-1:0]        head_idx;

    logic                 sel_we;
    logic [RF_ADDR_W-1:0] sel_wa;
    logic [XLEN-1:0]      sel_wd;

    assign p_wr       = pipe_wb_en && (pipe_wb_rd != '0);
    assign sec_ready  = !fifo_full;
    assign fifo_push  = sec_valid && !fifo_full;
    assign pipe_stall = (state == ARB_FORCE);
    assign push_entry = '{rd: sec_rd, data: sec_data};

    regfile_wb_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .push_entry (push_entry),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .slot_valid (slot_valid),
        .slot_rd    (slot_rd),
        .head_idx   (head_idx)
    );

    // Arbitration: choose this cycle's write source, pop and next counter/state.
    always_comb begin
        fifo_pop     = 1'b0;
        sel_we       = 1'b0;
        sel_wa       = '0;
        sel_wd       = '0;
        starve_cnt_n = starve_cnt;
        state_n      = state;
        if (state == ARB_FORCE) begin
            fifo_pop = !fifo_empty;
            if (!fifo_empty && fifo_head.rd != '0) begin
                sel_we = 1'b1;
                sel_wa = fifo_head.rd;
                sel_wd = fifo_head.data;
            end
            starve_cnt_n = '0;
            state_n      = ARB_PRIO;
        end else if (p_wr) begin
            sel_we = 1'b1;
            sel_wa = pipe_wb_rd;
            sel_wd = pipe_wb_data;
            if (!fifo_empty) begin
                // Counter saturates; the limit cycle also schedules the forced slot.
                if (starve_cnt == CNT_MAX) state_n = ARB_FORCE;
                else                       starve_cnt_n = starve_cnt + 1'b1;
            end
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            if (fifo_head.rd != '0) begin
                sel_we = 1'b1;
                sel_wa = fifo_head.rd;
                sel_wd = fifo_head.data;
            end
            starve_cnt_n = '0;
        end else begin
            starve_cnt_n = '0;
        end
    end

    // FSM state and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_PRIO;
            starve_cnt <= '0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_cnt_n;
        end
    end

    // Registered write port; address/data hold while no write is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= sel_we;
            if (sel_we) begin
                rf_wa <= sel_wa;
                rf_wd <= sel_wd;
            end
        end
    end

`ifdef WB_ARB_SCOREBOARD_EN
    logic [31:0] mask_n;
    logic        unused_fifo_view;

    assign unused_fifo_view = ^fifo_count;

    // Occupancy after this edge: surviving slots plus the entry being accepted.
    always_comb begin
        mask_n = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && !(fifo_pop && head_idx == AW'(i))) begin
                mask_n = mask_n | rd_onehot(slot_rd[i*RF_ADDR_W +: RF_ADDR_W]);
            end
        end
        if (fifo_push) mask_n = mask_n | rd_onehot(sec_rd);
    end

    // Registered pending-destination mask.
    always_ff @(posedge clk) begin
        if (rst) pending_mask <= '0;
        else     pending_mask <= mask_n;
    end
`else
    logic unused_fifo_view;

    assign unused_fifo_view = ^{fifo_count, slot_valid, slot_rd, head_idx};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: fixed vector table, directed
// corner-case sequences and randomized traffic against a queue-based model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wb_en;
    logic [4:0]  pipe_wb_rd;
    logic [31:0] pipe_wb_data;
    logic        pipe_stall;
    logic        sec_valid;
    logic [4:0]  sec_rd;
    logic [31:0] sec_data;
    logic        sec_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
`ifdef WB_ARB_SCOREBOARD_EN
    logic [31:0] pending_mask;
`endif

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wb_en   (pipe_wb_en),
        .pipe_wb_rd   (pipe_wb_rd),
        .pipe_wb_data (pipe_wb_data),
        .pipe_stall   (pipe_stall),
        .sec_valid    (sec_valid),
        .sec_rd       (sec_rd),
        .sec_data     (sec_data),
        .sec_ready    (sec_ready),
`ifdef WB_ARB_SCOREBOARD_EN
        .pending_mask (pending_mask),
`endif
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        sv;
        logic [4:0]  srd;
        logic [31:0] sd;
        logic        e_stall;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t        q[$];
    int          m_starve;
    bit          m_force;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    logic obs_stall;
    logic obs_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (q[i]) if (q[i].rd != 0) m[q[i].rd] = 1'b1;
        return m;
    endfunction

    task automatic model_write_entry(input ent_t e);
        if (e.rd != 0) begin
            m_we = 1'b1;
            m_wa = e.rd;
            m_wd = e.data;
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pipe_wb_en = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
        sec_valid = 1'b0; sec_rd = '0; sec_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_starve = 0; m_force = 1'b0;
        m_we = 1'b0; m_wa = '0; m_wd = '0;
        chk("reset_rf_we", {31'b0, rf_we}, 32'd0);
        chk("reset_rf_wa", {27'b0, rf_wa}, 32'd0);
        chk("reset_rf_wd", rf_wd, 32'd0);
        chk("reset_stall", {31'b0, pipe_stall}, 32'd0);
        chk("reset_ready", {31'b0, sec_ready}, 32'd1);
`ifdef WB_ARB_SCOREBOARD_EN
        chk("reset_mask", pending_mask, 32'd0);
`endif
    endtask

    // One clock: drive, check combinational outputs, advance model, check registers.
    task automatic cycle(input logic en, input logic [4:0] rd, input logic [31:0] d,
                         input logic sv, input logic [4:0] srd, input logic [31:0] sd);
        bit   e_stall, e_ready, accept, pwr;
        ent_t e;
        @(negedge clk);
        pipe_wb_en = en; pipe_wb_rd = rd; pipe_wb_data = d;
        sec_valid = sv; sec_rd = srd; sec_data = sd;
        e_stall = m_force;
        e_ready = (q.size() < DEPTH);
        #1;
        obs_stall = pipe_stall;
        obs_ready = sec_ready;
        chk("pipe_stall", {31'b0, pipe_stall}, {31'b0, e_stall});
        chk("sec_ready", {31'b0, sec_ready}, {31'b0, e_ready});
        accept = sv && e_ready;
        pwr = en && (rd != 0);
        if (m_force) begin
            e = q.pop_front();
            model_write_entry(e);
            m_starve = 0;
            m_force = 1'b0;
        end else if (pwr) begin
            m_we = 1'b1; m_wa = rd; m_wd = d;
            if (q.size() > 0) begin
                if (m_starve == LIMIT - 1) m_force = 1'b1;
                else                       m_starve++;
            end
        end else if (q.size() > 0) begin
            e = q.pop_front();
            model_write_entry(e);
            m_starve = 0;
        end else begin
            m_we = 1'b0;
            m_starve = 0;
        end
        if (accept) q.push_back('{rd: srd, data: sd});
        @(posedge clk);
        #1;
        chk("rf_we", {31'b0, rf_we}, {31'b0, m_we});
        chk("rf_wa", {27'b0, rf_wa}, {27'b0, m_wa});
        chk("rf_wd", rf_wd, m_wd);
`ifdef WB_ARB_SCOREBOARD_EN
        chk("pending_mask", pending_mask, model_mask());
`endif
    endtask

    initial begin
        vec_t vt[8];
        int   writes;
        int   en_pct;

        rst = 1'b1;
        pipe_wb_en = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
        sec_valid = 1'b0; sec_rd = '0; sec_data = '0;

        //        en rd  data           sv srd sdata        stall rdy we wa  wd
        vt[0] = '{1, 5,  32'hDEADBEEF,  0, 0,  32'h0,       0,    1,  1, 5,  32'hDEADBEEF};
        vt[1] = '{0, 0,  32'h0,         1, 3,  32'h11,      0,    1,  0, 5,  32'hDEADBEEF};
        vt[2] = '{1, 0,  32'h55,        0, 0,  32'h0,       0,    1,  1, 3,  32'h11};
        vt[3] = '{1, 0,  32'h66,        0, 0,  32'h0,       0,    1,  0, 3,  32'h11};
        vt[4] = '{1, 10, 32'h100,       1, 4,  32'h44,      0,    1,  1, 10, 32'h100};
        vt[5] = '{0, 0,  32'h0,         1, 0,  32'h99,      0,    1,  1, 4,  32'h44};
        vt[6] = '{0, 0,  32'h0,         0, 0,  32'h0,       0,    1,  0, 4,  32'h44};
        vt[7] = '{1, 31, 32'hFFFFFFFF,  0, 0,  32'h0,       0,    1,  1, 31, 32'hFFFFFFFF};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(vt[i].en, vt[i].rd, vt[i].d, vt[i].sv, vt[i].srd, vt[i].sd);
            chk("tbl_stall", {31'b0, obs_stall}, {31'b0, vt[i].e_stall});
            chk("tbl_ready", {31'b0, obs_ready}, {31'b0, vt[i].e_ready});
            chk("tbl_we", {31'b0, rf_we}, {31'b0, vt[i].e_we});
            chk("tbl_wa", {27'b0, rf_wa}, {27'b0, vt[i].e_wa});
            chk("tbl_wd", rf_wd, vt[i].e_wd);
        end

        // Starvation: one queued entry, continuous pipeline writes.
        do_reset();
        cycle(0, 0, 0, 1, 7, 32'hAA);
        writes = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 5'(i % 30 + 1), 32'(i), 0, 0, 0);
            if (obs_stall) break;
            writes++;
        end
        chk("starve_writes", 32'(writes), 32'd8);
        chk("starve_stall", {31'b0, obs_stall}, 32'd1);
        chk("force_wa", {27'b0, rf_wa}, 32'd7);
        chk("force_wd", rf_wd, 32'hAA);
        cycle(1, 2, 32'h22, 0, 0, 0);
        chk("after_force_stall", {31'b0, obs_stall}, 32'd0);
        chk("after_force_wa", {27'b0, rf_wa}, 32'd2);

        // Full FIFO with p_wr held, then in-order drain.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 5'(20 + i), 32'(i), 1, 5'(i + 1), 32'hA0 + 32'(i));
            chk("fill_ready", {31'b0, obs_ready}, 32'd1);
        end
        cycle(1, 24, 32'h4, 1, 5, 32'hB5);
        chk("full_ready", {31'b0, obs_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 0, 0);
            chk("drain_ready", {31'b0, obs_ready}, (i == 0) ? 32'd0 : 32'd1);
            chk("drain_we", {31'b0, rf_we}, 32'd1);
            chk("drain_wa", {27'b0, rf_wa}, 32'(i + 1));
            chk("drain_wd", rf_wd, 32'hA0 + 32'(i));
        end
        cycle(0, 0, 0, 0, 0, 0);
        chk("drain_empty_we", {31'b0, rf_we}, 32'd0);

        // Reset mid-drain.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'(i), 1, 5'(12 + i), 32'(i));
        cycle(0, 0, 0, 0, 0, 0);
        do_reset();
        cycle(0, 0, 0, 0, 0, 0);
        chk("post_reset_we", {31'b0, rf_we}, 32'd0);

`ifdef WB_ARB_SCOREBOARD_EN
        // Duplicate destination in the queue keeps its mask bit until both pop.
        do_reset();
        cycle(1, 1, 0, 1, 9, 32'h91);
        cycle(1, 1, 0, 1, 9, 32'h92);
        chk("sb_two", {31'b0, pending_mask[9]}, 32'd1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("sb_one", {31'b0, pending_mask[9]}, 32'd1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("sb_none", {31'b0, pending_mask[9]}, 32'd0);
`endif

        // Randomized traffic with varying pipeline density and rare resets.
        do_reset();
        en_pct = 95;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) en_pct = (n / 250 % 3 == 0) ? 95 : ((n / 250 % 3 == 1) ? 50 : 10);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 99) < en_pct),
                      ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                      $urandom(),
                      ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                      $urandom());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
